// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, data port and memory2c bus of the shared-memory
// arbiter. The arbiter takes the slave modport; requesters and the memory
// model take the master side.
interface mem_arbiter_if;
    // instruction-fetch port
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_ready;
    logic [15:0] if_data;
    // data-memory port
    logic        dm_req;
    logic        dm_wr;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_ready;
    logic [15:0] dm_rdata;
    // memory2c side
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;

    modport slave (
        input  if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_data_out,
        output if_ready, if_data, dm_ready, dm_rdata,
               mem_enable, mem_wr, mem_addr, mem_data_in
    );

    modport master (
        output if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_data_out,
        input  if_ready, if_data, dm_ready, dm_rdata,
               mem_enable, mem_wr, mem_addr, mem_data_in
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory2c between instruction fetch
// and the data port. One access at a time (IDLE -> ISSUE -> RESP), data wins
// ties. Define MEM_ARB_FAIRNESS_EN to add the fetch anti-starvation counter.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus,
    output logic         err
);
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
        $error("mem_arbiter: STARVE_LIMIT must be in 1..15");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE_D = 3'd1,
        ISSUE_I = 3'd2,
        RESP_D  = 3'd3,
        RESP_I  = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] hold_addr;
    logic [15:0] hold_wdata;
    logic        hold_wr;
    logic        grant_d;
    logic        grant_i;
    logic        force_i;
    logic        err_set;

`ifdef MEM_ARB_FAIRNESS_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt;

    // Count data grants that left fetch waiting; saturates at LIMIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d) begin
            if (!bus.if_req) begin
                starve_cnt <= '0;
            end else if (starve_cnt < LIMIT) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    assign force_i = (starve_cnt == LIMIT);
`else
    assign force_i = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the winner's request on the IDLE->ISSUE transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_addr  <= '0;
            hold_wdata <= '0;
            hold_wr    <= 1'b0;
        end else if (grant_d) begin
            hold_addr  <= bus.dm_addr;
            hold_wdata <= bus.dm_wdata;
            hold_wr    <= bus.dm_wr;
        end else if (grant_i) begin
            hold_addr  <= bus.if_addr;
            hold_wdata <= '0;
            hold_wr    <= 1'b0;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end
    end

    // Arbitration, next state and all port/memory outputs.
    always_comb begin
        state_next      = IDLE;
        grant_d         = 1'b0;
        grant_i         = 1'b0;
        err_set         = 1'b0;
        bus.if_ready    = 1'b0;
        bus.if_data     = '0;
        bus.dm_ready    = 1'b0;
        bus.dm_rdata    = '0;
        bus.mem_enable  = 1'b0;
        bus.mem_wr      = 1'b0;
        bus.mem_addr    = hold_addr;
        bus.mem_data_in = hold_wdata;

        case (state)
            IDLE: begin
                grant_i    = bus.if_req && (!bus.dm_req || force_i);
                grant_d    = bus.dm_req && !grant_i;
                state_next = grant_d ? ISSUE_D : (grant_i ? ISSUE_I : IDLE);
            end
            ISSUE_D: begin
                bus.mem_enable = 1'b1;
                bus.mem_wr     = hold_wr;
                err_set        = hold_addr[0] || !bus.dm_req;
                state_next     = RESP_D;
            end
            ISSUE_I: begin
                bus.mem_enable = 1'b1;
                err_set        = hold_addr[0] || !bus.if_req;
                state_next     = RESP_I;
            end
            RESP_D: begin
                bus.dm_ready = 1'b1;
                bus.dm_rdata = hold_wr ? '0 : bus.mem_data_out;
                err_set      = !bus.dm_req;
            end
            RESP_I: begin
                bus.if_ready = 1'b1;
                bus.if_data  = bus.mem_data_out;
                err_set      = !bus.if_req;
            end
            default: begin
                err_set    = 1'b1;
                state_next = IDLE;
            end
        endcase
    end
endmodule
